// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: redirect select codes
// and the instruction word width.
package fetch_buffer_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_EPC    = 2'b10,
        PCSRC_ERR    = 2'b11
    } pcsrc_e;

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Small first-word-fall-through FIFO with synchronous reset and flush.
// The head entry is visible on o_rdata whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues credit-limited in-order memory requests,
// queues returned instructions for decode and discards stale data after redirects.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_pcsrc,
    input  logic [ADDR_W-1:0]  i_execute,
    input  logic [ADDR_W-1:0]  i_epc_to_pc,
    input  logic [ADDR_W-1:0]  i_error_handler,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [31:0]        i_imem_rdata,
    output logic               o_fetch_valid,
    input  logic               i_fetch_ready,
    output logic [ADDR_W-1:0]  o_fetch_pc,
    output logic [31:0]        o_fetch_instr
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] r_fpc;
    logic [CW-1:0]     r_drop;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic [CW-1:0]     w_q_count;
    logic [CW-1:0]     w_outstanding;
    logic [CW:0]       w_credit_used;
    logic              w_grant;
    logic              w_rsp;
    logic              w_rsp_keep;
    logic              w_pop;
    logic              w_q_empty;
    logic              w_af_empty;
    logic [ADDR_W-1:0] w_af_addr;
    logic [QW-1:0]     w_q_rdata;
    logic [CW-1:0]     w_out_after_rsp;

    assign w_redirect    = (i_pcsrc != PCSRC_SEQ);
    assign w_credit_used = {1'b0, w_q_count} + {1'b0, w_outstanding};
    assign o_imem_req    = !i_rst && !w_redirect && (w_credit_used < (CW+1)'(DEPTH));
    assign o_imem_addr   = {r_fpc[ADDR_W-1:2], 2'b00};
    assign w_grant       = o_imem_req && i_imem_gnt;

    // The address FIFO mirrors every in-flight request, stale or not, so its
    // occupancy is the outstanding count and its head pairs with each response.
    assign w_rsp           = i_imem_rvalid && !w_af_empty;
    assign w_rsp_keep      = w_rsp && (r_drop == '0) && !w_redirect;
    assign w_out_after_rsp = w_outstanding - CW'(w_rsp);

    assign o_fetch_valid = !i_rst && !w_q_empty;
    assign w_pop         = o_fetch_valid && i_fetch_ready;
    assign o_fetch_pc    = w_q_rdata[QW-1:INSTR_W];
    assign o_fetch_instr = w_q_rdata[INSTR_W-1:0];

    always_comb begin
        w_target = r_fpc;
        case (i_pcsrc)
            PCSRC_BRANCH: w_target = i_execute;
            PCSRC_EPC:    w_target = i_epc_to_pc + ADDR_W'(4);
            PCSRC_ERR:    w_target = i_error_handler;
            default:      w_target = r_fpc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fpc <= RESET_PC;
        end else if (w_redirect) begin
            r_fpc <= w_target;
        end else if (w_grant) begin
            r_fpc <= r_fpc + ADDR_W'(4);
        end
    end

    // Everything still in flight after a redirect belongs to the old path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop <= '0;
        end else if (w_redirect) begin
            r_drop <= w_out_after_rsp;
        end else if (w_rsp && (r_drop != '0)) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (1'b0),
        .i_push  (w_grant),
        .i_wdata (o_imem_addr),
        .i_pop   (w_rsp),
        .o_rdata (w_af_addr),
        .o_empty (w_af_empty),
        .o_count (w_outstanding)
    );

    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_redirect),
        .i_push  (w_rsp_keep),
        .i_wdata ({w_af_addr, i_imem_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_q_rdata),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter ADDR_W, default 32: PC and instruction-address width.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2): instruction-queue entries and maximum outstanding memory requests.
REQ-003 Parameter RESET_PC, default 0: PC after reset.
REQ-004 i_clk  in  1: sole clock, all state on rising edge.
REQ-005 i_rst  in  1: synchronous reset, active-high.
REQ-006 i_pcsrc  in  2: redirect select (00 none, 01 branch target, 10 EPC+4, 11 error handler).
REQ-007 i_execute, i_epc_to_pc, i_error_handler  in  ADDR_W each: redirect targets for codes 01, 10, 11.
REQ-008 o_imem_req  out  1, o_imem_addr  out  ADDR_W, i_imem_gnt  in  1: request channel; transfer when req&&gnt.
REQ-009 i_imem_rvalid  in  1, i_imem_rdata  in  32: in-order response channel, no backpressure.
REQ-010 o_fetch_valid  out  1, i_fetch_ready  in  1, o_fetch_pc  out  ADDR_W, o_fetch_instr  out  32: decode handshake; transfer when valid&&ready.

Function
REQ-011 Fetch PC register (fpc) holds the next address to request; o_imem_addr SHALL equal fpc with bits [1:0] forced to 00.
REQ-012 o_imem_req SHALL be 1 iff not reset, i_pcsrc==00, and (queue count + outstanding) < DEPTH.
REQ-013 On request transfer, fpc SHALL advance by 4 (modulo 2^ADDR_W wrap) and outstanding SHALL increment; with req&&!gnt, fpc and o_imem_addr SHALL hold.
REQ-014 A valid response with drop counter zero SHALL write {pc, instr} into the queue tail, where pc is the address of the matching request (tracked in a DEPTH-entry in-order address FIFO), and SHALL decrement outstanding.
REQ-015 Queue SHALL be FIFO, first-word-fall-through: o_fetch_valid=1 whenever count>0; o_fetch_pc/o_fetch_instr show the head entry; pop on valid&&ready.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; push into full queue is impossible by REQ-012 credit rule.
REQ-017 Minimum latency: request granted in cycle N, response in N+1, o_fetch_valid in N+2.
REQ-018 Redirect (i_pcsrc!=00) in cycle N: fpc <= selected target (EPC code adds 4, all targets low bits cleared at address output), queue flushed (count=0), no request issued in N, o_fetch_valid=0 from N+1 until new data arrives.
REQ-019 Redirect SHALL set drop counter to outstanding (after counting any grant or response in cycle N); each later response with drop>0 SHALL be discarded, decrementing drop and outstanding.
REQ-020 A response arriving in the redirect cycle itself SHALL be discarded.
REQ-021 Pop in redirect cycle SHALL still complete (decode consumes head) before flush.
REQ-022 Back-to-back redirects SHALL each override; last target wins, drop counter recomputed each time.
REQ-023 With i_fetch_ready held 0, requests SHALL stop once count+outstanding==DEPTH and resume the cycle after a pop.

Reset
REQ-024 In the cycle i_rst=1: fpc=RESET_PC, count=0, outstanding=0, drop=0, queue pointers=0; o_imem_req=0, o_fetch_valid=0; o_fetch_pc/o_fetch_instr don't-care while valid=0.
REQ-025 Reset mid-operation SHALL abandon all in-flight requests; responses arriving after reset release SHALL be ignored only if drop logic covers them; system contract: memory is reset together with this block.
REQ-026 First request SHALL issue the cycle after i_rst deasserts, address RESET_PC.

Structure
REQ-027 Shared package: pcsrc encodings (PCSRC_SEQ, PCSRC_BRANCH, PCSRC_EPC, PCSRC_ERR) and instruction width constant 32.
REQ-028 One sub-module: sync_fifo (parametrised width/depth, FWFT, flush input), instantiated for the instruction queue and the in-flight address FIFO.
REQ-029 Counters sized $clog2(DEPTH)+1 bits.

Verification
REQ-030 Reset, gnt=1, 1-cycle memory returning addr as data, ready=1 -> PCs 0,4,8,C delivered on consecutive cycles, first valid 2 cycles after reset release.
REQ-031 ready=0, DEPTH=4 -> exactly 4 requests issued, req drops to 0, queue holds PCs 0..C; one pop -> one new request next cycle for 0x10.
REQ-032 3 requests outstanding, i_pcsrc=01 with i_execute=0x100 -> 3 following responses discarded, next delivered pc=0x100, no stale instr.
REQ-033 i_pcsrc=10, i_epc_to_pc=0x200 -> next request addr 0x204; i_pcsrc=11, i_error_handler=0x80000180 -> next request addr 0x80000180.
REQ-034 ADDR_W=32, fpc=0xFFFFFFFC -> next request addr 0x00000000 (wrap), no spurious redirect.
REQ-035 Random gnt/rvalid delays, random ready and redirects -> scoreboard: delivered pc sequence exactly matches golden in-order model, never exceeds DEPTH occupancy.
